// File: rtl/dct_pkg.sv
// Shared constants for the DCT quantize/zigzag stage: JPEG luminance table,
// its Q16 reciprocals, the zigzag scan order and the read-side FSM states.
package dct_pkg;

  localparam int BLOCK_SIZE = 64;

  // JPEG Annex K luminance quantization table, row-major.
  localparam int unsigned QTABLE [BLOCK_SIZE] = '{
    16, 11, 10, 16, 24, 40, 51, 61,
    12, 12, 14, 19, 26, 58, 60, 55,
    14, 13, 16, 24, 40, 57, 69, 56,
    14, 17, 22, 29, 51, 87, 80, 62,
    18, 22, 37, 56, 68, 109, 103, 77,
    24, 35, 55, 64, 81, 104, 113, 92,
    49, 64, 78, 87, 103, 121, 120, 101,
    72, 92, 95, 98, 112, 100, 103, 99
  };

  // round(65536 / QTABLE[k]), row-major.
  localparam int unsigned RECIP [BLOCK_SIZE] = '{
    4096, 5958, 6554, 4096, 2731, 1638, 1285, 1074,
    5461, 5461, 4681, 3449, 2521, 1130, 1092, 1192,
    4681, 5041, 4096, 2731, 1638, 1150,  950, 1170,
    4681, 3855, 2979, 2260, 1285,  753,  819, 1057,
    3641, 2979, 1771, 1170,  964,  601,  636,  851,
    2731, 1872, 1192, 1024,  809,  630,  580,  712,
    1337, 1024,  840,  753,  636,  542,  546,  649,
     910,  712,  690,  669,  585,  655,  636,  662
  };

  // Zigzag scan: ZZ[r] is the row-major index emitted at output position r.
  localparam int unsigned ZZ [BLOCK_SIZE] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  typedef enum logic {
    StIdle,
    StDrain
  } rd_state_e;

endpackage

// File: rtl/dct_quant_zigzag_ram.sv
// Ping-pong coefficient store: two 64-entry banks, one write port and one
// registered read port, each with its own bank select.
module qz_pingpong_ram
  import dct_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic             wr_bank,
  input  logic [5:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic             rd_bank,
  input  logic [5:0]       rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [2*BLOCK_SIZE];

  // Write and synchronous read; the bank select is the address MSB.
  always_ff @(posedge clk) begin
    if (wr_en) mem[{wr_bank, wr_addr}] <= wr_data;
    if (rd_en) rd_data <= mem[{rd_bank, rd_addr}];
  end

endmodule

// File: rtl/dct_quant_zigzag.sv
// Quantizes row-major 8x8 DCT blocks with the JPEG luminance table and
// re-emits them in zigzag order through a ping-pong buffer.
// Optional feature: define QZ_ZERO_CNT_EN to add o_zero_cnt, the number of
// zero quantized values in the block, valid with o_last.
module dct_quant_zigzag
  import dct_pkg::*;
#(
  parameter int DATA_WIDTH_IN  = 16,
  parameter int DATA_WIDTH_OUT = 12,
  parameter int RECIP_WIDTH    = 17
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_valid,
  input  logic signed [DATA_WIDTH_IN-1:0]  i_data,
  output logic                             o_valid,
  output logic signed [DATA_WIDTH_OUT-1:0] o_data,
  output logic                             o_last
`ifdef QZ_ZERO_CNT_EN
  ,
  output logic [6:0]                       o_zero_cnt
`endif
);

  localparam int MAG_W  = DATA_WIDTH_IN - 1;
  // One spare bit so the rounding add cannot overflow.
  localparam int PROD_W = MAG_W + RECIP_WIDTH + 1;
  localparam int QW     = PROD_W - 16;
  localparam logic [QW-1:0] POS_LIMIT = QW'(2 ** (DATA_WIDTH_OUT - 1) - 1);
  localparam logic [QW-1:0] NEG_LIMIT = QW'(2 ** (DATA_WIDTH_OUT - 1));
  localparam logic signed [DATA_WIDTH_OUT-1:0] OUT_MAX = {1'b0, {(DATA_WIDTH_OUT-1){1'b1}}};
  localparam logic signed [DATA_WIDTH_OUT-1:0] OUT_MIN = {1'b1, {(DATA_WIDTH_OUT-1){1'b0}}};

  // Input side
  logic [5:0]               wr_idx;
  logic [DATA_WIDTH_IN-1:0] in_abs;
  logic [MAG_W-1:0]         in_mag;
  logic                     s1_valid, s1_neg;
  logic [MAG_W-1:0]         s1_mag;
  logic [RECIP_WIDTH-1:0]   s1_recip;
  logic [5:0]               s1_k;
  logic [PROD_W-1:0]        prod;
  logic [QW-1:0]            q;
  logic signed [DATA_WIDTH_OUT-1:0] qsat;
  logic                     s2_valid;
  logic signed [DATA_WIDTH_OUT-1:0] s2_data;
  logic [5:0]               s2_k;

  // Bank bookkeeping and read side
  logic                     wr_last, wbank_q, rbank_q;
  logic [1:0]               full_q, full_now, full_d;
  rd_state_e                state_q;
  logic [5:0]               r_q, rd_addr;
  logic                     rd_en, rd_done, rd_en_q, last_q;
  logic [DATA_WIDTH_OUT-1:0] rd_data;

  // Magnitude of the incoming coefficient; the most negative code saturates.
  always_comb begin
    in_abs = i_data[DATA_WIDTH_IN-1] ? -i_data : i_data;
    in_mag = in_abs[DATA_WIDTH_IN-1] ? '1 : in_abs[MAG_W-1:0];
  end

  // S1: capture sign, magnitude, reciprocal and row-major index per beat.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      wr_idx   <= '0;
      s1_valid <= 1'b0;
      s1_neg   <= 1'b0;
      s1_mag   <= '0;
      s1_recip <= '0;
      s1_k     <= '0;
    end else begin
      s1_valid <= i_valid;
      if (i_valid) begin
        s1_neg   <= i_data[DATA_WIDTH_IN-1];
        s1_mag   <= in_mag;
        s1_recip <= RECIP_WIDTH'(RECIP[wr_idx]);
        s1_k     <= wr_idx;
        wr_idx   <= wr_idx + 6'd1;
      end
    end
  end

  // Reciprocal multiply, round half away from zero, restore sign, saturate.
  always_comb begin
    prod = PROD_W'(s1_mag) * PROD_W'(s1_recip);
    q    = QW'((prod + PROD_W'(32'h8000)) >> 16);
    if (s1_neg) qsat = (q > NEG_LIMIT) ? OUT_MIN : -DATA_WIDTH_OUT'(q);
    else        qsat = (q > POS_LIMIT) ? OUT_MAX : DATA_WIDTH_OUT'(q);
  end

  // S2: register the quantized value; it is written to the RAM next edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_k     <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= qsat;
        s2_k    <= s1_k;
      end
    end
  end

  assign wr_last = s2_valid && (s2_k == 6'(BLOCK_SIZE - 1));
  assign rd_en   = (state_q == StDrain);
  assign rd_done = rd_en && (r_q == 6'(BLOCK_SIZE - 1));
  assign rd_addr = 6'(ZZ[r_q]);

  // full_now includes a block completing this cycle, so the reader can start
  // (or chain) without waiting a cycle for the flag to register.
  always_comb begin
    full_now = full_q;
    if (wr_last) full_now[wbank_q] = 1'b1;
    full_d = full_now;
    if (rd_done) full_d[rbank_q] = 1'b0;
  end

  // Bank-full flags and write bank select.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      full_q  <= '0;
      wbank_q <= 1'b0;
    end else begin
      full_q <= full_d;
      if (wr_last) wbank_q <= ~wbank_q;
    end
  end

`ifdef QZ_ZERO_CNT_EN
  logic [6:0] zcnt_q [2];
  logic [6:0] zc_pipe_q;
  logic [6:0] s2_is_zero;
  assign s2_is_zero = {6'd0, (s2_data == '0)};

  // Per-bank zero count, restarted by the first write of each block.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      zcnt_q[0] <= '0;
      zcnt_q[1] <= '0;
    end else if (s2_valid) begin
      if (s2_k == 6'd0) zcnt_q[wbank_q] <= s2_is_zero;
      else              zcnt_q[wbank_q] <= zcnt_q[wbank_q] + s2_is_zero;
    end
  end
`endif

  // Read FSM plus the two-stage output pipeline (RAM read, output register).
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= StIdle;
      r_q     <= '0;
      rbank_q <= 1'b0;
      rd_en_q <= 1'b0;
      last_q  <= 1'b0;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_last  <= 1'b0;
`ifdef QZ_ZERO_CNT_EN
      zc_pipe_q  <= '0;
      o_zero_cnt <= '0;
`endif
    end else begin
      rd_en_q <= rd_en;
      last_q  <= rd_done;
      o_valid <= rd_en_q;
      o_last  <= last_q;
      o_data  <= rd_en_q ? rd_data : '0;
`ifdef QZ_ZERO_CNT_EN
      if (rd_done) zc_pipe_q  <= zcnt_q[rbank_q];
      if (last_q)  o_zero_cnt <= zc_pipe_q;
`endif
      unique case (state_q)
        StIdle: begin
          if (full_now[rbank_q]) begin
            state_q <= StDrain;
            r_q     <= '0;
          end
        end
        StDrain: begin
          r_q <= r_q + 6'd1;
          if (rd_done) begin
            rbank_q <= ~rbank_q;
            if (!full_now[~rbank_q]) state_q <= StIdle;
          end
        end
      endcase
    end
  end

  qz_pingpong_ram #(
    .WIDTH(DATA_WIDTH_OUT)
  ) u_ram (
    .clk    (i_clk),
    .wr_en  (s2_valid),
    .wr_bank(wbank_q),
    .wr_addr(s2_k),
    .wr_data(s2_data),
    .rd_en  (rd_en),
    .rd_bank(rbank_q),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

`ifndef SYNTHESIS
  // A block must never land in a bank that is still waiting to drain.
  always_ff @(posedge i_clk) begin
    if (i_rst && s2_valid) assert (!full_q[wbank_q]);
  end
`endif

endmodule

// File: tb/tb_dct_quant_zigzag.sv
// Scoreboard bench for dct_quant_zigzag.
module tb_dct_quant_zigzag;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic signed [15:0] in_data = '0;
  logic out_valid, out_last;
  logic signed [11:0] out_data;
`ifdef QZ_ZERO_CNT_EN
  logic [6:0] out_zc;
`endif

  always #5 clk = ~clk;

  dct_quant_zigzag dut (
    .i_clk  (clk),
    .i_rst  (rst_n),
    .i_valid(in_valid),
    .i_data (in_data),
    .o_valid(out_valid),
    .o_data (out_data),
    .o_last (out_last)
`ifdef QZ_ZERO_CNT_EN
    ,
    .o_zero_cnt(out_zc)
`endif
  );

  int tb_q [64] = '{
    16, 11, 10, 16, 24, 40, 51, 61,   12, 12, 14, 19, 26, 58, 60, 55,
    14, 13, 16, 24, 40, 57, 69, 56,   14, 17, 22, 29, 51, 87, 80, 62,
    18, 22, 37, 56, 68, 109, 103, 77, 24, 35, 55, 64, 81, 104, 113, 92,
    49, 64, 78, 87, 103, 121, 120, 101, 72, 92, 95, 98, 112, 100, 103, 99
  };
  int tb_zz [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  int errors = 0;
  int checks = 0;
  int exp_q[$];
  int zc_q[$];
  int out_count = 0;
  int run_len = 0;
  int max_run = 0;
  int blk [64];
  int expz [64];

  // Output monitor: pops the scoreboard on every valid beat.
  always @(negedge clk) begin
    int e;
    int ez;
    logic el;
    if (out_valid) begin
      run_len++;
      if (run_len > max_run) max_run = run_len;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got data=%0d last=%0b, required no output",
                 out_data, out_last);
      end else begin
        e  = exp_q.pop_front();
        el = ((out_count % 64) == 63);
        if (out_data !== 12'(e)) begin
          errors++;
          $display("FAIL data[%0d]: got %0d, required %0d", out_count % 64, out_data, e);
        end
        checks++;
        if (out_last !== el) begin
          errors++;
          $display("FAIL last[%0d]: got %0b, required %0b", out_count % 64, out_last, el);
        end
`ifdef QZ_ZERO_CNT_EN
        if (el) begin
          ez = zc_q.pop_front();
          checks++;
          if (out_zc !== 7'(ez)) begin
            errors++;
            $display("FAIL zero_cnt: got %0d, required %0d", out_zc, ez);
          end
        end
`endif
      end
      out_count++;
    end else begin
      run_len = 0;
    end
  end

  task automatic clear_blk();
    for (int i = 0; i < 64; i++) begin
      blk[i]  = 0;
      expz[i] = 0;
    end
  endtask

  task automatic push_block(input int zc);
    for (int i = 0; i < 64; i++) exp_q.push_back(expz[i]);
    zc_q.push_back(zc);
  endtask

  task automatic send_block(input int max_gap);
    for (int k = 0; k < 64; k++) begin
      if (max_gap > 0) begin
        int g;
        g = $urandom_range(max_gap, 0);
        repeat (g) begin
          in_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1;
      in_data  = 16'(blk[k]);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic wait_drain();
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d outputs pending, required 0", exp_q.size());
      exp_q.delete();
      zc_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %0b, required 0", out_valid);
    end
    checks++;
    if (out_data !== 12'sd0) begin
      errors++;
      $display("FAIL reset_data: got %0d, required 0", out_data);
    end
    checks++;
    if (out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_last: got %0b, required 0", out_last);
    end
`ifdef QZ_ZERO_CNT_EN
    checks++;
    if (out_zc !== 7'd0) begin
      errors++;
      $display("FAIL reset_zero_cnt: got %0d, required 0", out_zc);
    end
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_all_zero();
    int first;
    first = -1;
    clear_blk();
    push_block(64);
    send_block(0);
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(posedge clk); #1;
      if (out_valid && first < 0) first = cyc;
    end
    checks++;
    if (first !== 4) begin
      errors++;
      $display("FAIL latency: first o_valid after %0d cycles, required 4", first);
    end
    wait_drain();
  endtask

  task automatic test_dc_rounding();
    int din  [6] = '{160, -24, 24, -8, 32767, -32768};
    int dout [6] = '{10, -2, 2, -1, 2047, -2048};
    for (int t = 0; t < 6; t++) begin
      clear_blk();
      blk[0]  = din[t];
      expz[0] = dout[t];
      push_block(63);
      send_block(0);
    end
    wait_drain();
  endtask

  task automatic test_zigzag();
    clear_blk();
    blk[1]  = 11;
    blk[8]  = 12;
    blk[16] = 14;
    expz[1] = 1;
    expz[2] = 1;
    expz[3] = 1;
    push_block(61);
    send_block(0);
    wait_drain();
  endtask

  // Every position carries n*Q so the quantized value is exactly n.
  task automatic test_zigzag_full();
    int n [64];
    clear_blk();
    for (int k = 0; k < 64; k++) begin
      n[k]   = (k % 31) - 15;
      blk[k] = n[k] * tb_q[k];
    end
    for (int i = 0; i < 64; i++) expz[i] = n[tb_zz[i]];
    push_block(2);
    send_block(0);
    wait_drain();
  endtask

  task automatic test_back_to_back(input int max_gap);
    max_run = 0;
    for (int b = 1; b <= 3; b++) begin
      clear_blk();
      blk[0]  = 16 * b;
      expz[0] = b;
      push_block(63);
    end
    for (int b = 1; b <= 3; b++) begin
      clear_blk();
      blk[0] = 16 * b;
      send_block(max_gap);
    end
    wait_drain();
    if (max_gap == 0) begin
      checks++;
      if (max_run !== 192) begin
        errors++;
        $display("FAIL continuous_run: got %0d beats, required 192", max_run);
      end
    end
  endtask

  task automatic test_mid_block_reset();
    for (int k = 0; k < 30; k++) begin
      in_valid = 1'b1;
      in_data  = 16'sd1000;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_data  = '0;
    rst_n    = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_blk();
    blk[0]  = 16;
    expz[0] = 1;
    push_block(63);
    send_block(0);
    wait_drain();
    repeat (100) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_dc_rounding();
    test_zigzag();
    test_zigzag_full();
    test_back_to_back(0);
    test_back_to_back(3);
    test_mid_block_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/dct_quant_zigzag.md
Name: dct_quant_zigzag

Overview:
- Stage directly downstream of the 2-D DCT.
- Consumes signed DCT coefficients, one 8x8 block at a time, arriving in row-major order.
- Quantizes each coefficient with the JPEG luminance table using reciprocal multiply and round-half-away-from-zero, then saturates.
- Re-emits the 64 quantized values per block in zigzag order for the entropy coder, using a ping-pong buffer so input runs at full rate.

Parameters:
DATA_WIDTH_IN, 16, signed coefficient width from the DCT
DATA_WIDTH_OUT, 12, signed quantized output width
RECIP_WIDTH, 17, unsigned reciprocal width, Q16 format (65536/Q)

Ports:
i_clk  input  1  clock
i_rst  input  1  synchronous reset, active-low
i_valid  input  1  coefficient beat valid; gaps allowed, no backpressure
i_data  input  DATA_WIDTH_IN  signed coefficient, row-major index k = 8*row+col
o_valid  output  1  quantized coefficient valid
o_data  output  DATA_WIDTH_OUT  signed quantized coefficient, zigzag order
o_last  output  1  high with 64th output beat of a block

Behaviour:
- Clock and reset: one clock, i_clk. Reset is synchronous and active-low on i_rst. While i_rst=0:
  - o_valid=0, o_data=0, o_last=0.
  - Write index=0, write bank=0, both bank-full flags cleared, read FSM=IDLE.
  - Partial blocks and pending blocks are discarded. Memory contents need not be cleared.
- Quantizer pipeline (2 stages, advances only on valid beats; bubbles pass through):
  - S1: register sign, |c| (saturate -32768 to 32767), RECIP[k], k.
  - S2: p = |c|*RECIP[k]; q = (p + 2^15) >> 16; apply sign.
  - Saturate to [-(2^(W-1)), 2^(W-1)-1] with W=DATA_WIDTH_OUT; write to bank[wbank][k].
- Write side:
  - 6-bit counter k increments per accepted beat.
  - When the write at k=63 completes, set full[wbank], toggle wbank, k wraps to 0.
- Read FSM: IDLE -> DRAIN when full[rbank]=1. DRAIN -> IDLE after r=63.
  - Bank addressed at ZZ[r], r=0..63. Synchronous read, 1-cycle latency.
  - Output is 64 consecutive o_valid beats with no gaps.
  - On the last beat: clear full[rbank], toggle rbank.
  - If the other bank is already full, go straight back to DRAIN with no idle cycle.
- Latency: first o_valid exactly 4 cycles after the edge sampling the 64th input beat, when the read side is idle.
- Overflow cannot occur: a block needs >=64 input cycles to fill and drain takes exactly 64 cycles.
  - Simultaneous set (write side) and clear (read side) of different banks' full flags in the same cycle are both honoured.
  - Assertion: a write never targets a bank with full=1.
- Zigzag mapping ZZ[0..7] = 0,1,8,16,9,2,3,10; the rest follows the standard JPEG scan, ending at 63.

Optional Feature:
- Macro QZ_ZERO_CNT_EN.
- Defined:
  - Adds output o_zero_cnt[6:0]. Reset 0.
  - Valid in the o_last cycle: number of zero quantized values in that block (0..64).
  - Counted at write time and stored per bank.
- Undefined: port and counters absent; all other behaviour identical.

Decomposition:
- Package dct_pkg holds:
  - QTABLE[64] (JPEG Annex K luminance table).
  - RECIP[64] = round(65536/QTABLE).
  - ZZ[64] scan LUT.
  - BLOCK_SIZE=64.
  - Read FSM state enum.
- One sub-module, qz_pingpong_ram: two 64xDATA_WIDTH_OUT banks, 1 write port, 1 synchronous read port, bank-select inputs.

Test Plan:
- All-zero block, 64 back-to-back beats -> 64 outputs of 0; o_last on 64th; first o_valid 4 cycles after last input.
- DC-only: k0=160, others 0 (Q=16) -> output 10 then 63 zeros. Rounding: k0=-24 -> -2; k0=24 -> 2; k0=-8 -> -1.
- Saturation: k0=32767 -> 2047; k0=-32768 -> -2048.
- Zigzag: k1=11, k8=12, k16=14 (all others 0) -> output positions 1,2,3 = 1,1,1; positions 0 and 4..63 = 0.
- Three back-to-back blocks with DC 16, 32, 48 at full rate -> 192 continuous output beats (o_valid high throughout, one-cycle gaps forbidden); DC values 1, 2, 3. Repeat with random i_valid gaps and check the same values.
- Reset: drop i_rst low for 1 cycle after 30 beats of a block, then send a full block with DC=16 -> partial data never appears; only one block output, DC=1. With QZ_ZERO_CNT_EN, o_zero_cnt=63.
